// File: rtl/ahb_reg_slave.sv
// AHB-Lite register-file responder: word-addressed registers with byte-lane writes,
// a fixed number of wait states per OKAY transfer and a two-cycle ERROR response.
module ahb_reg_slave #(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int AHB_DATA_WIDTH = 32,
   parameter int REG_WORDS      = 16,
   parameter int WAIT_STATES    = 1
) (
   input  logic                      ahb_clk_in,
   input  logic                      ahb_rst_in,
   input  logic                      ahb_sel_in,
   input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
   input  logic [1:0]                ahb_trans_in,
   input  logic                      ahb_write_in,
   input  logic [2:0]                ahb_size_in,
   input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
   input  logic                      ahb_ready_in,
   output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
   output logic                      ahb_ready_out,
   output logic                      ahb_resp_out
);
   localparam int         IDX_W     = $clog2(REG_WORDS);
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t                    state_q, state_d;
   logic                      ready_q, ready_d;
   logic                      resp_q, resp_d;
   logic [3:0]                cnt_q, cnt_d;
   logic [IDX_W+1:0]          addr_q, addr_d;
   logic                      write_q, write_d;
   logic [2:0]                size_q, size_d;
   logic [AHB_DATA_WIDTH-1:0] regs_q [REG_WORDS];
   logic [AHB_DATA_WIDTH-1:0] regs_d [REG_WORDS];

   logic             accept;
   logic             addr_err;
   logic [IDX_W-1:0] idx;
   logic [3:0]       lane_en;
   logic             unused_trans;

   // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
   assign unused_trans = ahb_trans_in[0];
   assign accept       = ahb_sel_in && ahb_trans_in[1] && ahb_ready_in;
   assign idx          = addr_q[IDX_W+1:2];

   always_comb begin
      addr_err = 1'b0;
      if (ahb_size_in > 3'd2)                                  addr_err = 1'b1;
      if (ahb_size_in == 3'd1 && ahb_addr_in[0])               addr_err = 1'b1;
      if (ahb_size_in == 3'd2 && ahb_addr_in[1:0] != 2'b00)    addr_err = 1'b1;
      if (ahb_addr_in[AHB_ADDR_WIDTH-1:IDX_W+2] != '0)         addr_err = 1'b1;
      if (int'(ahb_addr_in[IDX_W+1:2]) >= REG_WORDS)           addr_err = 1'b1;
   end

   always_comb begin
      case (size_q)
         3'd0:    lane_en = 4'b0001 << addr_q[1:0];
         3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_DATA;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               addr_d  = ahb_addr_in[IDX_W+1:0];
               write_d = ahb_write_in;
               size_d  = ahb_size_in;
               if (addr_err) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
      endcase
      ready_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
      resp_d  = (state_d == ST_ERR1 || state_d == ST_ERR2);
   end

   // Commit happens on the edge that leaves DATA; error transfers never get there.
   always_comb begin
      for (int w = 0; w < REG_WORDS; w++) regs_d[w] = regs_q[w];
      if (state_q == ST_DATA && write_q) begin
         for (int b = 0; b < 4; b++)
            if (lane_en[b]) regs_d[idx][8*b +: 8] = ahb_wdata_in[8*b +: 8];
      end
   end

   always_ff @(posedge ahb_clk_in) begin
      if (ahb_rst_in) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         resp_q  <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         resp_q  <= resp_d;
         cnt_q   <= cnt_d;
      end
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
   end

   always_ff @(posedge ahb_clk_in) begin
      if (ahb_rst_in) begin
         for (int w = 0; w < REG_WORDS; w++) regs_q[w] <= '0;
      end else begin
         for (int w = 0; w < REG_WORDS; w++) regs_q[w] <= regs_d[w];
      end
   end

   assign ahb_rdata_out = (state_q == ST_DATA && !write_q) ? regs_q[idx] : '0;
   assign ahb_ready_out = ready_q;
   assign ahb_resp_out  = resp_q;
endmodule

// File: tb/tb_ahb_reg_slave.sv
// Bench for ahb_reg_slave: one instance with no wait states and one with a single wait
// state, driven by directed and random transfers against a byte-level register model.
module tb_ahb_reg_slave;
   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic        clk = 1'b0;
   logic        rst      [2];
   logic        sel      [2];
   logic [31:0] addr     [2];
   logic [1:0]  trans    [2];
   logic        write    [2];
   logic [2:0]  size     [2];
   logic [31:0] wdata    [2];
   logic        ready_in [2];
   logic [31:0] rdata    [2];
   logic        ready_out[2];
   logic        resp     [2];

   logic [31:0] mem [2][16];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign ready_in[0] = ready_out[0];
   assign ready_in[1] = ready_out[1];

   ahb_reg_slave #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .REG_WORDS(16), .WAIT_STATES(0)) u_dut0 (
      .ahb_clk_in(clk), .ahb_rst_in(rst[0]), .ahb_sel_in(sel[0]), .ahb_addr_in(addr[0]),
      .ahb_trans_in(trans[0]), .ahb_write_in(write[0]), .ahb_size_in(size[0]),
      .ahb_wdata_in(wdata[0]), .ahb_ready_in(ready_in[0]), .ahb_rdata_out(rdata[0]),
      .ahb_ready_out(ready_out[0]), .ahb_resp_out(resp[0]));

   ahb_reg_slave #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .REG_WORDS(16), .WAIT_STATES(1)) u_dut1 (
      .ahb_clk_in(clk), .ahb_rst_in(rst[1]), .ahb_sel_in(sel[1]), .ahb_addr_in(addr[1]),
      .ahb_trans_in(trans[1]), .ahb_write_in(write[1]), .ahb_size_in(size[1]),
      .ahb_wdata_in(wdata[1]), .ahb_ready_in(ready_in[1]), .ahb_rdata_out(rdata[1]),
      .ahb_ready_out(ready_out[1]), .ahb_resp_out(resp[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
      return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) || (a >= 32'd64);
   endfunction

   task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
      logic [31:0] base;
      logic [31:0] ba;
      base = {a[31:2], 2'b00};
      for (int b = 0; b < 4; b++) begin
         ba = base + 32'(b);
         if (ba >= a && ba < a + (32'd1 << sz)) mem[d][a[5:2]][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   task automatic do_reset(input int d);
      rst[d] = 1'b1; trans[d] = T_IDLE;
      @(posedge clk); @(negedge clk);
      rst[d] = 1'b0;
      for (int w = 0; w < 16; w++) mem[d][w] = '0;
   endtask

   // Starts at a negedge with the slave able to accept; ends at a negedge inside the
   // final data-phase cycle so the next call can overlap its address phase.
   task automatic xfer(input int d, input logic [1:0] tr, input bit wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd, input string tag,
                       output logic [31:0] rd);
      bit          err;
      logic [31:0] exp_rd;
      err = is_err(a, sz);
      sel[d] = 1'b1; trans[d] = tr; addr[d] = a; write[d] = wr; size[d] = sz;
      @(posedge clk); @(negedge clk);
      trans[d] = T_IDLE; wdata[d] = wd;
      if (err) begin
         chk({tag, "/err1_ready"}, 32'(ready_out[d]), 32'd0);
         chk({tag, "/err1_resp"},  32'(resp[d]),      32'd1);
         @(negedge clk);
         chk({tag, "/err2_ready"}, 32'(ready_out[d]), 32'd1);
         chk({tag, "/err2_resp"},  32'(resp[d]),      32'd1);
         chk({tag, "/err2_rdata"}, rdata[d],          32'd0);
      end else begin
         for (int i = 0; i < d; i++) begin
            chk({tag, "/wait_ready"}, 32'(ready_out[d]), 32'd0);
            chk({tag, "/wait_resp"},  32'(resp[d]),      32'd0);
            chk({tag, "/wait_rdata"}, rdata[d],          32'd0);
            @(negedge clk);
         end
         exp_rd = wr ? 32'd0 : mem[d][a[5:2]];
         chk({tag, "/data_ready"}, 32'(ready_out[d]), 32'd1);
         chk({tag, "/data_resp"},  32'(resp[d]),      32'd0);
         chk({tag, "/data_rdata"}, rdata[d],          exp_rd);
         if (wr) model_write(d, a, sz, wd);
      end
      rd = rdata[d];
   endtask

   task automatic gap(input int d, input string tag);
      case ($urandom_range(0, 2))
         0:       begin sel[d] = 1'b0; trans[d] = T_NSEQ; end
         1:       begin sel[d] = 1'b1; trans[d] = T_BUSY; end
         default: begin sel[d] = 1'b1; trans[d] = T_IDLE; end
      endcase
      addr[d] = $urandom; write[d] = 1'($urandom);
      @(posedge clk); @(negedge clk);
      chk({tag, "/gap_ready"}, 32'(ready_out[d]), 32'd1);
      chk({tag, "/gap_resp"},  32'(resp[d]),      32'd0);
      chk({tag, "/gap_rdata"}, rdata[d],          32'd0);
      trans[d] = T_IDLE;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      logic [2:0]  sz;
      int          r;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; sel[d] = 1'b0; addr[d] = '0; trans[d] = T_IDLE;
         write[d] = 1'b0; size[d] = 3'd2; wdata[d] = '0;
      end
      @(negedge clk);
      do_reset(0); do_reset(1);

      // T1: idle traffic after reset, every register reads zero
      for (int d = 0; d < 2; d++) begin
         sel[d] = 1'b1;
         repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("t1_ready", 32'(ready_out[d]), 32'd1);
            chk("t1_resp",  32'(resp[d]),      32'd0);
            chk("t1_rdata", rdata[d],          32'd0);
         end
         for (int w = 0; w < 16; w++) begin
            xfer(d, T_NSEQ, 1'b0, 32'(w * 4), 3'd2, '0, "t1_read", rd);
            chk("t1_zero", rd, 32'd0);
         end
      end

      // T2/T3 on the one-wait-state slave
      xfer(1, T_NSEQ, 1'b1, 32'h0, 3'd2, 32'hDEADBEEF, "t2_wr", rd);
      xfer(1, T_NSEQ, 1'b0, 32'h0, 3'd2, '0, "t2_rd", rd);
      chk("t2_value", rd, 32'hDEADBEEF);
      xfer(1, T_NSEQ, 1'b1, 32'h3, 3'd0, 32'hAA000000, "t3_wrb", rd);
      xfer(1, T_NSEQ, 1'b1, 32'h4, 3'd1, 32'h00001234, "t3_wrh", rd);
      xfer(1, T_NSEQ, 1'b0, 32'h0, 3'd2, '0, "t3_rd0", rd);
      chk("t3_value0", rd, 32'hAAADBEEF);
      xfer(1, T_NSEQ, 1'b0, 32'h4, 3'd2, '0, "t3_rd4", rd);
      chk("t3_value4", rd, 32'h00001234);

      // T4: misaligned word write and out-of-range read
      xfer(1, T_NSEQ, 1'b1, 32'h2, 3'd2, 32'h55555555, "t4_wr", rd);
      xfer(1, T_NSEQ, 1'b0, 32'h40, 3'd2, '0, "t4_rd", rd);
      xfer(1, T_NSEQ, 1'b0, 32'h0, 3'd2, '0, "t4_chk", rd);
      chk("t4_unchanged", rd, 32'hAAADBEEF);
      trans[1] = T_IDLE;

      // T5: back-to-back burst on the zero-wait slave
      for (int i = 0; i < 4; i++)
         xfer(0, (i == 0) ? T_NSEQ : T_SEQ, 1'b1, 32'(i * 4), 3'd2, 32'hC0DE0000 + 32'(i), "t5_wr", rd);
      xfer(0, T_NSEQ, 1'b0, 32'hC, 3'd2, '0, "t5_rd", rd);
      chk("t5_value", rd, 32'hC0DE0003);

      // Random traffic on both slaves
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) gap(d, "rnd");
            a = 32'($urandom_range(0, 79));
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(6, 31));
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 3'(r) : ((r < 9) ? 3'd2 : 3'($urandom_range(3, 7)));
            if (sz == 3'd2 && $urandom_range(0, 3) != 0) a = a & ~32'h3;
            xfer(d, $urandom_range(0, 1) ? T_SEQ : T_NSEQ, 1'($urandom), a, sz, $urandom, "rnd", rd);
         end
         for (int w = 0; w < 16; w++) xfer(d, T_NSEQ, 1'b0, 32'(w * 4), 3'd2, '0, "sweep", rd);
         trans[d] = T_IDLE;
      end

      // T6: reset during the wait cycle of a write to 0x8
      xfer(1, T_NSEQ, 1'b1, 32'h8, 3'd2, 32'h11112222, "t6_pre", rd);
      sel[1] = 1'b1; trans[1] = T_NSEQ; addr[1] = 32'h8; write[1] = 1'b1; size[1] = 3'd2;
      @(posedge clk); @(negedge clk);
      chk("t6_wait_ready", 32'(ready_out[1]), 32'd0);
      trans[1] = T_IDLE; wdata[1] = 32'hFFFFFFFF; rst[1] = 1'b1;
      @(posedge clk); @(negedge clk);
      rst[1] = 1'b0;
      for (int w = 0; w < 16; w++) mem[1][w] = '0;
      chk("t6_ready", 32'(ready_out[1]), 32'd1);
      chk("t6_resp",  32'(resp[1]),      32'd0);
      repeat (2) @(negedge clk);
      chk("t6_idle_ready", 32'(ready_out[1]), 32'd1);
      xfer(1, T_NSEQ, 1'b0, 32'h8, 3'd2, '0, "t6_rd", rd);
      chk("t6_reg2", rd, 32'd0);
      trans[1] = T_IDLE;
      @(posedge clk); @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
